// File: rtl/seg7_pkg.sv
// Shared constants for 7-segment display stages:
// active-low segment codes {g,f,e,d,c,b,a} and blink mode encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] MODE_NORMAL  = 2'd0;
    localparam logic [1:0] MODE_LOW     = 2'd1;
    localparam logic [1:0] MODE_EXPIRED = 2'd2;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD to active-low 7-segment decoder.
// Non-decimal codes 10..15 decode to a blank digit.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed 7-segment driver with low-time and
// expired blink alerts; all pins are registered.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 4,
    parameter int BLINK_HALF = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] val1,
    input  logic [3:0] val2,
    input  logic [3:0] val3,
    input  logic [3:0] val4,
    input  logic       low_time,
    input  logic       expired,
    output logic [6:0] led_seg,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       a4
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = $clog2(BLINK_HALF);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] LOW_LAST = BLK_W'(BLINK_HALF - 1);
    localparam logic [BLK_W-1:0] EXP_LAST = BLK_W'(BLINK_HALF / 2 - 1);

    logic [DIV_W-1:0] div_q;
    logic [1:0]       idx_q;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic [BLK_W-1:0] blink_cnt_q;
    logic [BLK_W-1:0] blink_last;
    logic             phase_q;
    logic [3:0]       digit;
    logic [6:0]       dec_seg;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;

    always_comb begin
        mode_d = MODE_NORMAL;
        if (expired)
            mode_d = MODE_EXPIRED;
        else if (low_time)
            mode_d = MODE_LOW;
    end

    always_comb begin
        blink_last = EXP_LAST;
        if (mode_q == MODE_LOW)
            blink_last = LOW_LAST;
    end

    always_comb begin
        digit = val1;
        unique case (idx_q)
            2'd0: digit = val1;
            2'd1: digit = val2;
            2'd2: digit = val3;
            2'd3: digit = val4;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= 2'd0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // A mode change restarts the blink visible so every alert
    // sequence begins with the digits shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_NORMAL;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            mode_q <= mode_d;
            if (mode_d != mode_q || mode_q == MODE_NORMAL) begin
                blink_cnt_q <= '0;
                phase_q     <= 1'b1;
            end else if (blink_cnt_q == blink_last) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !phase_q) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= dec_seg;
        end
    end

    assign led_seg = seg_q;
    assign a1      = an_q[0];
    assign a2      = an_q[1];
    assign a3      = an_q[2];
    assign a4      = an_q[3];

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Downstream display stage of the parking meter: consumes the four BCD digits produced by `parking_meter` (`val1`..`val4`) plus two status flags, and time-multiplexes them onto one shared 7-segment bus with four active-low anodes. It also applies the meter's visual alerts: a slow blink when time is low and a fast blink when time is expired. All outputs are registered so the board pins are glitch-free.

## Interface
- `SCAN_DIV`, 4: clock cycles each digit stays lit; minimum 1.
- `BLINK_HALF`, 8: half-period of the low-time blink, in clock cycles; must be even and at least 2.
- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `val1`..`val4`  in  4 each  BCD digits; `val1` is the leftmost digit (thousands) and drives anode `a1`.
- `low_time`  in  1  remaining time is nonzero and under threshold.
- `expired`  in  1  remaining time is zero; takes priority over `low_time`.
- `led_seg`  out  7  segment bus {g,f,e,d,c,b,a}, active-low.
- `a1`..`a4`  out  1 each  digit anodes, active-low; at most one is low at a time.

## Operation
- **Scan.**
  - Divider counts 0..SCAN_DIV-1; on terminal count the 2-bit digit index advances 0→1→2→3→0.
  - Index k selects `val(k+1)` and anode `a(k+1)`.
- **Decode** (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10..15 decode to blank (1111111).
- **Mode register.**
  - `mode_q` is registered each cycle from the inputs: EXPIRED if `expired`; else LOW if `low_time`; else NORMAL.
- **Blink.**
  - Phase bit starts at ON; a counter toggles it.
  - LOW: phase toggles every BLINK_HALF cycles.
  - EXPIRED: phase toggles every BLINK_HALF/2 cycles.
  - NORMAL: phase is held ON and the counter is held at 0.
  - On any change of `mode_q`, the counter clears and phase returns to ON, so every blink sequence starts visible.
- **Blanking.**
  - When phase is OFF, all anodes are 1 and `led_seg` is 1111111.
  - Scan index and divider keep running during blank; blinking does not disturb scan position.
- **Sampling.** `val` is re-read every cycle. A digit change mid-slot appears on the next output update.

## Timing
- **Reset values.** While `rst` is high, at each edge: `a1`..`a4`=1, `led_seg`=1111111, index=0, divider=0, blink counter=0, phase=ON, `mode_q`=NORMAL.
- **First output after reset.** The first edge after `rst` falls registers `a1`=0 and `led_seg`=decode(`val1`).
- **Datapath latency.** One cycle from index/val to pins.
- **Slot timing.** Each anode is low for exactly SCAN_DIV consecutive cycles; a full frame is 4·SCAN_DIV cycles.
- **Mode latency.** Input-flag change to visible effect is 2 cycles (`mode_q` register, then output register).
- **Mid-operation reset.** `rst` asserted mid-slot or mid-blink blanks outputs at that edge; scan restarts at `a1`.
- **Simultaneous flags.** `expired`=`low_time`=1 behaves exactly as EXPIRED.
- **Boundary: blink rollover.** Blink counter rollover coinciding with a slot boundary applies both updates on the same edge.

## Structure
- Shared package `seg7_pkg` holds:
  - the 7-bit segment constants for 0..9;
  - `SEG_BLANK` = 7'b1111111;
  - the mode encoding `MODE_NORMAL`/`MODE_LOW`/`MODE_EXPIRED` (2 bits).
- Sub-module `bcd_to_seg7`: combinational, 4-bit in, 7-bit active-low out, blank for codes 10..15. It is reused by any other display.
- Top level contains:
  - scan divider and digit index;
  - `mode_q` register;
  - blink counter and phase bit;
  - digit mux and output registers.

## Test plan
All cases use SCAN_DIV=4 and BLINK_HALF=8.
- **Reset and first frame.** Hold `rst` 2 cycles → `a1`..`a4`=1, `led_seg`=1111111. Release with vals 1,2,3,4 →
  - `a1` low 4 cycles with 1111001;
  - then `a2` with 0100100;
  - then `a3` with 0110000;
  - then `a4` with 0011001;
  - frame repeats at cycle 16 starting from `a1`.
- **Invalid digit.** `val3`=4'hA → the `a3` slot shows 1111111 while `a3`=0; other digits are unaffected.
- **Low-time blink.** `low_time`=1 → starting 2 cycles later, display visible 8 cycles, blank 8 cycles, repeating. The anode index observed after each blank continues where the scan would be.
- **Expired blink and priority.** Raise `expired` while `low_time`=1 →
  - blink restarts visible;
  - toggle every 4 cycles;
  - `val`=0,0,0,0 shows 1000000 on each anode in turn.
- **Mode change while blanked.** Drop both flags during an OFF phase → full display returns 2 cycles later and stays on.
- **Reset mid-blink.** Assert `rst` during an OFF phase of EXPIRED → outputs stay blank during reset. After release with flags low, the first edge shows `a1` lit with decode(`val1`).
